// File: rtl/i2c_target_responder.sv
// I2C target responder: filters SCL/SDA, detects START/STOP, matches a 7-bit
// address, ACKs writes and serves read bytes from a request/data interface.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   scl_i, sda_i          synchronised pad inputs
//   sda_en_o              open-drain SDA pull-down enable
//   enable_i              target enable, sampled at the address compare
//   target_addr_i         own 7-bit address (7'h00 never matches)
//   start_o, stop_o       bus condition pulses (stop_o only when addressed)
//   wr_valid_o/data/first received write byte
//   rd_req_o, rd_data_i   read byte request; data sampled one cycle later
//   nack_o                controller NACKed a read byte
//   busy_o                target currently addressed
module i2c_target_responder #(
    parameter int unsigned FilterCycles = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_en_o,
    input  logic       enable_i,
    input  logic [6:0] target_addr_i,
    output logic       start_o,
    output logic       stop_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_data_o,
    output logic       wr_first_o,
    output logic       rd_req_o,
    input  logic [7:0] rd_data_i,
    output logic       nack_o,
    output logic       busy_o
);

    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
    } state_e;

    state_e            state_q;
    logic              scl_f_q, sda_f_q, scl_p_q, sda_p_q;
    logic [CntW-1:0]   scl_cnt_q, sda_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        sr_q;
    logic              rw_q, first_q, load_q;

    logic scl_rise, scl_fall, sda_rise, sda_fall, scl_hi, start_cond, stop_cond;

    // Glitch filter: filtered value follows raw after FilterCycles differing cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            if (scl_i == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CntW'(FilterCycles - 1)) begin
                scl_f_q   <= scl_i;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 4'd1;
            end
            if (sda_i == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CntW'(FilterCycles - 1)) begin
                sda_f_q   <= sda_i;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 4'd1;
            end
        end
    end

    assign scl_rise   =  scl_f_q & ~scl_p_q;
    assign scl_fall   = ~scl_f_q &  scl_p_q;
    assign sda_rise   =  sda_f_q & ~sda_p_q;
    assign sda_fall   = ~sda_f_q &  sda_p_q;
    // SCL must have been high on both samples; a simultaneous SCL edge is data
    assign scl_hi     =  scl_f_q &  scl_p_q;
    assign start_cond =  sda_fall & scl_hi;
    assign stop_cond  =  sda_rise & scl_hi;

    // Protocol FSM with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            load_q     <= 1'b0;
            sda_en_o   <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_data_o  <= 8'h00;
            wr_first_o <= 1'b0;
            rd_req_o   <= 1'b0;
            nack_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            nack_o     <= 1'b0;
            load_q     <= 1'b0;
            if (start_cond) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                start_o   <= 1'b1;
                sda_en_o  <= 1'b0;
            end else if (stop_cond) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                sda_en_o  <= 1'b0;
                stop_o    <= busy_o;
                busy_o    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_ADDR: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            sr_q      <= {sr_q[6:0], sda_f_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rw_q <= sda_f_q;
                                // sr_q[6:0] holds the seven address bits here
                                if (!(enable_i && target_addr_i != 7'h00 &&
                                      sr_q[6:0] == target_addr_i)) begin
                                    state_q   <= S_WAIT;
                                    bit_cnt_q <= '0;
                                    busy_o    <= 1'b0;
                                end
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            state_q   <= S_ADDR_ACK;
                            bit_cnt_q <= '0;
                            sda_en_o  <= 1'b1;
                            busy_o    <= 1'b1;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            sda_en_o  <= 1'b0;
                            if (rw_q) begin
                                state_q  <= S_RD_DATA;
                                rd_req_o <= 1'b1;
                            end else begin
                                state_q <= S_WR_DATA;
                                first_q <= 1'b1;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            sr_q      <= {sr_q[6:0], sda_f_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                wr_valid_o <= 1'b1;
                                wr_data_o  <= {sr_q[6:0], sda_f_q};
                                wr_first_o <= first_q;
                                first_q    <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            state_q   <= S_WR_ACK;
                            bit_cnt_q <= '0;
                            sda_en_o  <= 1'b1;
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            state_q   <= S_WR_DATA;
                            bit_cnt_q <= '0;
                            sda_en_o  <= 1'b0;
                        end
                    end
                    S_RD_DATA: begin
                        // rd_req_o high now -> rd_data_i valid in the next cycle
                        if (rd_req_o) begin
                            load_q <= 1'b1;
                        end else if (load_q) begin
                            sr_q      <= rd_data_i;
                            sda_en_o  <= ~rd_data_i[7];
                            bit_cnt_q <= 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q   <= S_RD_ACK;
                                bit_cnt_q <= '0;
                                sda_en_o  <= 1'b0;
                            end else begin
                                sr_q      <= {sr_q[6:0], 1'b0};
                                sda_en_o  <= ~sr_q[6];
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        // bit_cnt_q = 1 marks an ACK seen, waiting for the fall
                        if (scl_rise && bit_cnt_q == 4'd0) begin
                            if (sda_f_q) begin
                                nack_o  <= 1'b1;
                                state_q <= S_WAIT;
                            end else begin
                                bit_cnt_q <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            state_q   <= S_RD_DATA;
                            bit_cnt_q <= '0;
                            rd_req_o  <= 1'b1;
                        end
                    end
                    S_WAIT: sda_en_o <= 1'b0;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
module tb_i2c_target_responder;

    localparam int unsigned Q = 8;
    localparam logic [2:0] EV_START = 3'd0, EV_STOP = 3'd1, EV_WR = 3'd2,
                           EV_RDREQ = 3'd3, EV_NACK = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
        logic       first;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       enable_i = 1'b1;
    logic [6:0] target_addr_i = 7'h50;
    logic [7:0] rd_data_i = 8'h00;
    logic       sda_en_o, start_o, stop_o, wr_valid_o, wr_first_o;
    logic       rd_req_o, nack_o, busy_o;
    logic [7:0] wr_data_o;
    logic       sda_bus;

    assign sda_bus = sda_drv & ~sda_en_o;

    always #5 clk = ~clk;

    i2c_target_responder #(.FilterCycles(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(scl_drv), .sda_i(sda_bus),
        .sda_en_o(sda_en_o), .enable_i(enable_i), .target_addr_i(target_addr_i),
        .start_o(start_o), .stop_o(stop_o), .wr_valid_o(wr_valid_o),
        .wr_data_o(wr_data_o), .wr_first_o(wr_first_o), .rd_req_o(rd_req_o),
        .rd_data_i(rd_data_i), .nack_o(nack_o), .busy_o(busy_o)
    );

    int   n_tests = 0;
    int   n_fail = 0;
    int   n_start = 0;
    int   n_stop = 0;
    int   n_busy_fall = 0;
    ev_t  sb[$];
    logic [7:0] rdq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] k, input logic [7:0] d, input logic f);
        ev_t e;
        e.kind = k; e.data = d; e.first = f;
        return e;
    endfunction

    task automatic sb_check(input ev_t act);
        ev_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got event kind %0d data 0x%0h, expected none", act.kind, act.data);
        end else begin
            e = sb.pop_front();
            check("sb_event", 32'(act), 32'(e));
        end
    endtask

    // Monitor: compare every DUT pulse against the scoreboard queue
    initial begin
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (start_o)    begin n_start++; sb_check(mk(EV_START, 8'h00, 1'b0)); end
                if (stop_o)     begin n_stop++;  sb_check(mk(EV_STOP,  8'h00, 1'b0)); end
                if (wr_valid_o) sb_check(mk(EV_WR, wr_data_o, wr_first_o));
                if (rd_req_o)   sb_check(mk(EV_RDREQ, 8'h00, 1'b0));
                if (nack_o)     sb_check(mk(EV_NACK,  8'h00, 1'b0));
            end
            if (busy_prev && !busy_o) n_busy_fall++;
            busy_prev = busy_o;
        end
    end

    // Read data responder
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req_o) rd_data_i = (rdq.size() != 0) ? rdq.pop_front() : 8'hFF;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_drv = b; wq();
        scl_drv = 1'b1; wq();
        s = sda_bus; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b1; wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(~ack, s);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         st0, sp0, bf0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({sda_en_o, start_o, stop_o, wr_valid_o, wr_data_o,
                                   wr_first_o, rd_req_o, nack_o, busy_o}), 32'd0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk);

        // Write to 0x50: 0x12, 0x34
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        write_byte(8'hA0, ack);  check("wr_addr_ack", 32'(ack), 32'd1);
        check("wr_busy_set", 32'(busy_o), 32'd1);
        sb.push_back(mk(EV_WR, 8'h12, 1'b1));
        write_byte(8'h12, ack);  check("wr_b1_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_WR, 8'h34, 1'b0));
        write_byte(8'h34, ack);  check("wr_b2_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_STOP, 8'h00, 1'b0));
        i2c_stop();
        check("wr_busy_clear", 32'(busy_o), 32'd0);

        // Read 0x5A (ACK) then 0xC3 (NACK)
        rdq.push_back(8'h5A);
        rdq.push_back(8'hC3);
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        sb.push_back(mk(EV_RDREQ, 8'h00, 1'b0));
        write_byte(8'hA1, ack);  check("rd_addr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_RDREQ, 8'h00, 1'b0));
        read_byte(1'b1, d);      check("rd_byte1", 32'(d), 32'h5A);
        sb.push_back(mk(EV_NACK, 8'h00, 1'b0));
        read_byte(1'b0, d);      check("rd_byte2", 32'(d), 32'hC3);
        check("rd_sda_released", 32'(sda_en_o), 32'd0);
        sb.push_back(mk(EV_STOP, 8'h00, 1'b0));
        i2c_stop();
        check("rd_busy_clear", 32'(busy_o), 32'd0);

        // Address mismatch and disabled target
        sp0 = n_stop;
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        write_byte(8'hA2, ack);  check("mis_addr_nack", 32'(ack), 32'd0);
        check("mis_busy", 32'(busy_o), 32'd0);
        i2c_stop();
        enable_i = 1'b0;
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        write_byte(8'hA0, ack);  check("dis_addr_nack", 32'(ack), 32'd0);
        write_byte(8'h55, ack);  check("dis_data_nack", 32'(ack), 32'd0);
        check("dis_busy", 32'(busy_o), 32'd0);
        i2c_stop();
        enable_i = 1'b1;
        check("mis_no_stop", 32'(n_stop - sp0), 32'd0);

        // Repeated START: write 0x07, Sr, read 0x99 with NACK
        st0 = n_start; bf0 = n_busy_fall;
        rdq.push_back(8'h99);
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        write_byte(8'hA0, ack);  check("sr_addr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_WR, 8'h07, 1'b1));
        write_byte(8'h07, ack);  check("sr_wr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        check("sr_busy_held", 32'(busy_o), 32'd1);
        sb.push_back(mk(EV_RDREQ, 8'h00, 1'b0));
        write_byte(8'hA1, ack);  check("sr_rd_addr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_NACK, 8'h00, 1'b0));
        read_byte(1'b0, d);      check("sr_rd_byte", 32'(d), 32'h99);
        sb.push_back(mk(EV_STOP, 8'h00, 1'b0));
        i2c_stop();
        check("sr_start_count", 32'(n_start - st0), 32'd2);
        check("sr_busy_one_fall", 32'(n_busy_fall - bf0), 32'd1);
        check("sr_wr_data_held", 32'(wr_data_o), 32'h07);

        // Glitch filter: 1-cycle SDA pulse ignored, 3-cycle pulse is a START
        st0 = n_start;
        repeat (5) @(negedge clk);
        sda_drv = 1'b0; @(negedge clk); sda_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_no_start", 32'(n_start - st0), 32'd0);
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        sda_drv = 1'b0; repeat (3) @(negedge clk); sda_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_3cyc_start", 32'(n_start - st0), 32'd1);

        // Reset while driving the address ACK
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        for (int i = 7; i >= 0; i--) clk_bit(1'(8'hA0 >> i), s);
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        check("rst_ack_driven", 32'(sda_en_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("rst_sda_release", 32'(sda_en_o), 32'd0);
        check("rst_busy_clear", 32'(busy_o), 32'd0);
        @(negedge clk); rst_i = 1'b0;
        scl_drv = 1'b0; wq();
        i2c_stop();
        sb.push_back(mk(EV_START, 8'h00, 1'b0));
        i2c_start();
        write_byte(8'hA0, ack);  check("post_rst_addr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_WR, 8'h3C, 1'b1));
        write_byte(8'h3C, ack);  check("post_rst_wr_ack", 32'(ack), 32'd1);
        sb.push_back(mk(EV_STOP, 8'h00, 1'b0));
        i2c_stop();

        repeat (20) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
